// File: rtl/display_pkg.sv
// Shared constants, FSM state type and elaboration helpers for the BCD display driver.
// Optional feature macro used by dependants: LEADING_ZERO_BLANK_EN.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_encoder.sv
// Combinational nibble to active-low 7-segment pattern; dash wins over blank,
// and non-decimal nibbles (10..15) also render as a dash.
module seven_seg_encoder
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    if (i_dash || (i_nibble > 4'd9)) begin
      o_seg = SEG_DASH;
    end else if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      o_seg = SEG_DIGIT[i_nibble];
    end
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Iterative double-dabble binary-to-BCD converter driving DIGITS active-low 7-segment displays.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module bcd_display_driver
  import display_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_binary,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [7*DIGITS-1:0]   o_segs
);

  localparam int unsigned SW = 4 * DIGITS + 4;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam longint unsigned POW = pow10(DIGITS);
  // A threshold too large for DATA_W+1 bits saturates, so overflow can never fire.
  localparam bit LIMIT_FITS = (DATA_W >= 63) || (POW < (64'd1 << (DATA_W + 1)));
  localparam logic [DATA_W:0] OVF_LIMIT = LIMIT_FITS ? (DATA_W + 1)'(POW) : '1;

  function automatic logic [7*DIGITS-1:0] seg_reset_pattern();
    logic [7*DIGITS-1:0] p;
    for (int k = 0; k < int'(DIGITS); k++) begin
      p[7*k +: 7] = SEG_DIGIT[0];
    end
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 1; k < int'(DIGITS); k++) begin
      p[7*k +: 7] = SEG_BLANK;
    end
`endif
    return p;
  endfunction

  localparam logic [7*DIGITS-1:0] SEGS_RESET = seg_reset_pattern();

  state_t                r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_bin;
  logic [DATA_W-1:0]     r_shift;
  logic [SW-1:0]         r_scratch;
  logic                  r_done;
  logic                  r_overflow;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [7*DIGITS-1:0]   r_segs;

  logic [SW-1:0]         w_adj;
  logic [SW-1:0]         w_scratch_next;
  logic                  w_unused_adj_msb;
  logic                  w_overflow;
  logic [4*DIGITS-1:0]   w_bcd;
  logic [DIGITS-1:0]     w_blank;
  logic [7*DIGITS-1:0]   w_segs;

  // FSM: state register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_state_next = SHIFT;
      SHIFT:   if (r_cnt == LAST_CNT) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy = (r_state == SHIFT);
  end

  // Add-3 correction on every nibble, then shift in the next binary MSB.
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < int'(DIGITS) + 1; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
    end
    w_scratch_next = {w_adj[SW-2:0], r_shift[DATA_W-1]};
  end

  assign w_unused_adj_msb = w_adj[SW-1];

  assign w_overflow = ({1'b0, r_bin} >= OVF_LIMIT);
  assign w_bcd      = w_overflow ? '1 : r_scratch[4*DIGITS-1:0];

  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_digit
`ifdef LEADING_ZERO_BLANK_EN
    if (k == 0) begin : g_ones
      assign w_blank[k] = 1'b0;
    end else begin : g_upper
      assign w_blank[k] = ~|r_scratch[4*DIGITS-1:4*k];
    end
`else
    assign w_blank[k] = 1'b0;
`endif
    seven_seg_encoder u_enc (
      .i_nibble (r_scratch[4*k +: 4]),
      .i_blank  (w_blank[k]),
      .i_dash   (w_overflow),
      .o_seg    (w_segs[7*k +: 7])
    );
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt      <= '0;
      r_bin      <= '0;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_bcd      <= '0;
      r_segs     <= SEGS_RESET;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_bin     <= i_binary;
            r_shift   <= i_binary;
            r_scratch <= '0;
            r_cnt     <= '0;
          end
        end
        SHIFT: begin
          r_scratch <= w_scratch_next;
          r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
          r_cnt     <= r_cnt + 1'b1;
        end
        DONE: begin
          r_done     <= 1'b1;
          r_bcd      <= w_bcd;
          r_segs     <= w_segs;
          r_overflow <= w_overflow;
        end
        default: ;
      endcase
    end
  end

  assign o_done     = r_done;
  assign o_overflow = r_overflow;
  assign o_bcd      = r_bcd;
  assign o_segs     = r_segs;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed self-checking bench for bcd_display_driver (default DATA_W=32, DIGITS=4).
// Expectations follow LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_bcd_display_driver;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [27:0] SEGS_RST  = {SB, SB, SB, S0};
  localparam logic [27:0] SEGS_7    = {SB, SB, SB, S7};
  localparam logic [27:0] SEGS_105  = {SB, S1, S0, S5};
`else
  localparam logic [27:0] SEGS_RST  = {S0, S0, S0, S0};
  localparam logic [27:0] SEGS_7    = {S0, S0, S0, S7};
  localparam logic [27:0] SEGS_105  = {S0, S1, S0, S5};
`endif
  localparam logic [27:0] SEGS_1234 = {S1, S2, S3, S4};
  localparam logic [27:0] SEGS_9999 = {S9, S9, S9, S9};
  localparam logic [27:0] SEGS_DASH = {SD, SD, SD, SD};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] bin;
  logic        busy, done, ovf;
  logic [15:0] bcd;
  logic [27:0] segs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bcd_display_driver #(
    .DATA_W (32),
    .DIGITS (4)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_binary   (bin),
    .o_busy     (busy),
    .o_done     (done),
    .o_overflow (ovf),
    .o_bcd      (bcd),
    .o_segs     (segs)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle start pulse, then wait (bounded) for done and check latency and outputs.
  task automatic convert(input logic [31:0] v, input string tag, input logic [15:0] exp_bcd,
                         input logic [27:0] exp_segs, input logic exp_ovf);
    int lat;
    start = 1'b1;
    bin   = v;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 32'hDEAD_BEEF;
    check_eq({tag, ".busy"}, 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, ".latency"}, 64'(lat), 64'd33);
    check_eq({tag, ".bcd"}, 64'(bcd), 64'(exp_bcd));
    check_eq({tag, ".segs"}, 64'(segs), 64'(exp_segs));
    check_eq({tag, ".ovf"}, 64'(ovf), 64'(exp_ovf));
    @(posedge clk); #1;
    check_eq({tag, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat;
    int n_done;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.busy", 64'(busy), 64'd0);
    check_eq("rst.done", 64'(done), 64'd0);
    check_eq("rst.ovf", 64'(ovf), 64'd0);
    check_eq("rst.bcd", 64'(bcd), 64'd0);
    check_eq("rst.segs", 64'(segs), 64'(SEGS_RST));
    rst = 1'b0;
    @(posedge clk); #1;

    convert(32'd1234, "v1234", 16'h1234, SEGS_1234, 1'b0);
    convert(32'd9999, "v9999", 16'h9999, SEGS_9999, 1'b0);
    convert(32'd10000, "v10000", 16'hFFFF, SEGS_DASH, 1'b1);
    convert(32'd0, "v0", 16'h0000, SEGS_RST, 1'b0);
    convert(32'hFFFF_FFFF, "vmax", 16'hFFFF, SEGS_DASH, 1'b1);
    convert(32'd7, "v7", 16'h0007, SEGS_7, 1'b0);
    convert(32'd105, "v105", 16'h0105, SEGS_105, 1'b0);

    // start held high: done-to-done spacing is DATA_W+2
    start = 1'b1;
    bin   = 32'd9999;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 100);
    start = 1'b0;
    check_eq("b2b.period", 64'(lat), 64'd34);
    check_eq("b2b.bcd", 64'(bcd), 64'h9999);

    // start while busy is ignored
    start = 1'b1;
    bin   = 32'd1234;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    bin   = 32'd42;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check_eq("busy_start.ndone", 64'(n_done), 64'd1);
    check_eq("busy_start.bcd", 64'(bcd), 64'h1234);

    // leave overflow/dashes set, then abort a conversion with reset
    convert(32'd10000, "pre_abort", 16'hFFFF, SEGS_DASH, 1'b1);
    start = 1'b1;
    bin   = 32'd1234;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort.busy", 64'(busy), 64'd0);
    check_eq("abort.done", 64'(done), 64'd0);
    check_eq("abort.ovf", 64'(ovf), 64'd0);
    check_eq("abort.bcd", 64'(bcd), 64'd0);
    check_eq("abort.segs", 64'(segs), 64'(SEGS_RST));
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check_eq("abort.ndone", 64'(n_done), 64'd0);
    convert(32'd1234, "post_abort", 16'h1234, SEGS_1234, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
